// File: rtl/program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// program_loader : host byte stream -> little-endian 32-bit imem writes; holds cpuReset until loaded (rev 1.0)
// ----------------------------------------------------------------------------
module program_loader #(
  parameter int                ADDR_W      = 64,
  parameter int                DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [31:0]       imemData,
  output logic              imemWrite,
  output logic              cpuReset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [1:0]        lane_q,  lane_d;
  logic [31:0]       word_q,  word_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]       data_q,  data_d;
  logic              xfer;
  logic [15:0]       hdr_n;

  assign byteReady = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
  assign imemWrite = (state_q == S_WRITE);
  assign busy      = byteReady || imemWrite;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign cpuReset  = (state_q != S_DONE);
  assign imemAddr  = addr_q;
  assign imemData  = data_q;

  assign xfer  = byteValid & byteReady;
  assign hdr_n = {byteIn, count_q[7:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_HDR0;
      end
      S_HDR0: begin
        if (xfer) begin
          count_d = {8'h00, byteIn};
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          count_d = hdr_n;
          if ((hdr_n == 16'h0000) || ({16'h0000, hdr_n} > DEPTH_LIMIT)) begin
            state_d = S_ERR;
          end else begin
            idx_d   = '0;
            lane_d  = 2'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{lane_q, 3'b000} +: 8] = byteIn;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            // Output registers only change here, so they hold outside WRITE.
            data_d  = {byteIn, word_q[23:0]};
            addr_d  = BASE_ADDR + (ADDR_W'(idx_q) << 2);
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (32'(idx_q) == (32'(count_q) - 32'd1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_program_loader : directed checks of program_loader (default base and BASE_ADDR=0x100) (rev 1.0)
// ----------------------------------------------------------------------------
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset, start, byteValid;
  logic [7:0]  byteIn;

  logic        byteReady, imemWrite, cpuReset, busy, done, error;
  logic [63:0] imemAddr;
  logic [31:0] imemData;

  logic        b_byteReady, b_imemWrite, b_cpuReset, b_busy, b_done, b_error;
  logic [63:0] b_imemAddr;
  logic [31:0] b_imemData;

  int          total = 0;
  int          bad   = 0;
  int          wr_n  = 0;
  int          wr2_n = 0;
  int          rdy_bad = 0;
  logic [63:0] wr_addr [300];
  logic [31:0] wr_data [300];
  logic [63:0] wr2_addr[16];
  logic [7:0]  stream[$];

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .imemAddr(imemAddr), .imemData(imemData), .imemWrite(imemWrite),
    .cpuReset(cpuReset), .busy(busy), .done(done), .error(error)
  );

  program_loader #(.BASE_ADDR(64'h100)) dut_b (
    .clk(clk), .reset(reset), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(b_byteReady), .imemAddr(b_imemAddr), .imemData(b_imemData), .imemWrite(b_imemWrite),
    .cpuReset(b_cpuReset), .busy(b_busy), .done(b_done), .error(b_error)
  );

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (imemWrite === 1'b1) begin
      if (wr_n < 300) begin
        wr_addr[wr_n] = imemAddr;
        wr_data[wr_n] = imemData;
      end
      if (byteReady !== 1'b0) rdy_bad++;
      wr_n++;
    end
    if (b_imemWrite === 1'b1) begin
      if (wr2_n < 16) wr2_addr[wr2_n] = b_imemAddr;
      wr2_n++;
    end
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    byteValid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    byteIn    = b;
    byteValid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (byteReady === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL byte_accept: byte %02h not accepted within 40 cycles, ready=%0b required 1", b, byteReady);
    end
  endtask

  task automatic send_stream(input int maxgap);
    foreach (stream[i]) send_byte(stream[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    byteValid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int strobes = 0;
    reset = 1'b1;
    settle(2);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (imemWrite !== 1'b0) strobes++;
      total++;
      if ({cpuReset, byteReady, busy, done, error} !== 5'b10000 || imemAddr !== 64'h0 || imemData !== 32'h0) begin
        bad++;
        $display("FAIL reset_idle c=%0d: got cpuReset/ready/busy/done/error=%b addr=%h data=%h required 10000/0/0",
                 c, {cpuReset, byteReady, busy, done, error}, imemAddr, imemData);
      end
    end
    total++;
    if (strobes !== 0 || b_imemAddr !== 64'h100) begin
      bad++;
      $display("FAIL reset_nostrobe: got strobes=%0d baseB=%h required 0 / 100", strobes, b_imemAddr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    wr_n = 0;
    do_start();
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || byteReady !== 1'b1 || cpuReset !== 1'b1) begin
      bad++;
      $display("FAIL load_hdr0: got busy=%0b ready=%0b cpuReset=%0b required 1 1 1", busy, byteReady, cpuReset);
    end
    @(posedge clk); #1;
    stream = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h80, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h14};
    send_stream(0);
    @(negedge clk);
    total++;
    if (imemWrite !== 1'b1 || byteReady !== 1'b0 || done !== 1'b0 || cpuReset !== 1'b1) begin
      bad++;
      $display("FAIL load_last_write: got wr=%0b ready=%0b done=%0b cpuReset=%0b required 1 0 0 1",
               imemWrite, byteReady, done, cpuReset);
    end
    @(negedge clk);
    total++;
    if (imemWrite !== 1'b0 || done !== 1'b1 || cpuReset !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL load_done: got wr=%0b done=%0b cpuReset=%0b busy=%0b required 0 1 0 0",
               imemWrite, done, cpuReset, busy);
    end
    @(posedge clk); #1;
    total++;
    if (wr_n !== 2 || wr_addr[0] !== 64'h0 || wr_data[0] !== 32'hD2800020 ||
        wr_addr[1] !== 64'h4 || wr_data[1] !== 32'h14000000) begin
      bad++;
      $display("FAIL load_writes: got n=%0d (%h,%h) (%h,%h) required 2 (0,d2800020) (4,14000000)",
               wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    total++;
    if (imemAddr !== 64'h4 || imemData !== 32'h14000000) begin
      bad++;
      $display("FAIL load_hold: got addr=%h data=%h required 4 14000000", imemAddr, imemData);
    end
  endtask

  task automatic test_gaps();
    wr_n = 0;
    rdy_bad = 0;
    do_start();
    @(negedge clk);
    total++;
    if (cpuReset !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL gaps_restart: got cpuReset=%0b done=%0b busy=%0b required 1 0 1", cpuReset, done, busy);
    end
    @(posedge clk); #1;
    stream = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h80, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h14};
    send_stream(3);
    settle(3);
    total++;
    if (wr_n !== 2 || wr_addr[0] !== 64'h0 || wr_data[0] !== 32'hD2800020 ||
        wr_addr[1] !== 64'h4 || wr_data[1] !== 32'h14000000 || done !== 1'b1) begin
      bad++;
      $display("FAIL gaps_writes: got n=%0d (%h,%h) (%h,%h) done=%0b required 2 (0,d2800020) (4,14000000) 1",
               wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], done);
    end
    total++;
    if (rdy_bad !== 0) begin
      bad++;
      $display("FAIL gaps_ready_in_write: got %0d write cycles with byteReady=1 required 0", rdy_bad);
    end
  endtask

  task automatic test_bad_header();
    wr_n = 0;
    do_start();
    stream = '{8'h00, 8'h00};
    send_stream(0);
    @(negedge clk);
    total++;
    if (error !== 1'b1 || cpuReset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || byteReady !== 1'b0) begin
      bad++;
      $display("FAIL hdr_zero: got error=%0b cpuReset=%0b busy=%0b done=%0b ready=%0b required 1 1 0 0 0",
               error, cpuReset, busy, done, byteReady);
    end
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    total++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL hdr_err_restart: got error=%0b busy=%0b required 0 1", error, busy);
    end
    @(posedge clk); #1;
    stream = '{8'h01, 8'h01};
    send_stream(0);
    @(negedge clk);
    total++;
    if (error !== 1'b1 || cpuReset !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL hdr_257: got error=%0b cpuReset=%0b done=%0b required 1 1 0", error, cpuReset, done);
    end
    @(posedge clk); #1;
    settle(2);
    total++;
    if (wr_n !== 0) begin
      bad++;
      $display("FAIL hdr_no_writes: got %0d writes required 0", wr_n);
    end
    do_start();
    stream = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_stream(1);
    settle(2);
    total++;
    if (done !== 1'b1 || error !== 1'b0 || cpuReset !== 1'b0 || wr_n !== 1 ||
        wr_addr[0] !== 64'h0 || wr_data[0] !== 32'h12345678) begin
      bad++;
      $display("FAIL hdr_recover: got done=%0b error=%0b cpuReset=%0b n=%0d (%h,%h) required 1 0 0 1 (0,12345678)",
               done, error, cpuReset, wr_n, wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] iv;
    wr_n = 0;
    do_start();
    stream = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      stream.push_back(iv);
      stream.push_back(8'hA5);
      stream.push_back(8'h00);
      stream.push_back(~iv);
    end
    send_stream(0);
    settle(2);
    total++;
    if (wr_n !== 256 || done !== 1'b1 || error !== 1'b0) begin
      bad++;
      $display("FAIL depth_256: got n=%0d done=%0b error=%0b required 256 1 0", wr_n, done, error);
    end
    total++;
    if (wr_addr[255] !== 64'h3FC || wr_data[255] !== 32'h0000A5FF || wr_data[17] !== 32'hEE00A511) begin
      bad++;
      $display("FAIL depth_last: got (%h,%h) w17=%h required (3fc,0000a5ff) w17=ee00a511",
               wr_addr[255], wr_data[255], wr_data[17]);
    end
  endtask

  task automatic test_reset_mid_and_busy_start();
    int strobes = 0;
    wr_n = 0;
    do_start();
    send_byte(8'h03, 0);
    byteValid = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || byteReady !== 1'b1 || error !== 1'b0) begin
      bad++;
      $display("FAIL busy_start: got busy=%0b ready=%0b error=%0b required 1 1 0", busy, byteReady, error);
    end
    @(posedge clk); #1;
    stream = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(0);
    reset     = 1'b1;
    byteValid = 1'b1;
    byteIn    = 8'h77;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({cpuReset, byteReady, imemWrite, busy, done, error} !== 6'b100000 ||
        imemAddr !== 64'h0 || imemData !== 32'h0 || b_imemAddr !== 64'h100) begin
      bad++;
      $display("FAIL mid_reset_vals: got cpuReset/ready/wr/busy/done/error=%b addr=%h data=%h addrB=%h required 100000 0 0 100",
               {cpuReset, byteReady, imemWrite, busy, done, error}, imemAddr, imemData, b_imemAddr);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imemWrite !== 1'b0 || byteReady !== 1'b0) strobes++;
    end
    @(posedge clk); #1;
    byteValid = 1'b0;
    total++;
    if (strobes !== 0 || wr_n !== 1 || wr_addr[0] !== 64'h0 || wr_data[0] !== 32'h44332211) begin
      bad++;
      $display("FAIL mid_reset_writes: got bad_cycles=%0d n=%0d (%h,%h) required 0 1 (0,44332211)",
               strobes, wr_n, wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_base_addr();
    do_start();
    stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream(0);
    settle(2);
    total++;
    if (b_done !== 1'b1 || b_cpuReset !== 1'b0) begin
      bad++;
      $display("FAIL base_first_load: got done=%0b cpuReset=%0b required 1 0", b_done, b_cpuReset);
    end
    wr2_n = 0;
    do_start();
    @(negedge clk);
    total++;
    if (b_cpuReset !== 1'b1 || b_done !== 1'b0 || b_busy !== 1'b1) begin
      bad++;
      $display("FAIL base_restart: got cpuReset=%0b done=%0b busy=%0b required 1 0 1", b_cpuReset, b_done, b_busy);
    end
    @(posedge clk); #1;
    stream = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_stream(0);
    settle(2);
    total++;
    if (wr2_n !== 2 || wr2_addr[0] !== 64'h100 || wr2_addr[1] !== 64'h104 ||
        b_imemData !== 32'h08070605 || b_done !== 1'b1) begin
      bad++;
      $display("FAIL base_addrs: got n=%0d a0=%h a1=%h data=%h done=%0b required 2 100 104 08070605 1",
               wr2_n, wr2_addr[0], wr2_addr[1], b_imemData, b_done);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    byteValid = 1'b0;
    byteIn    = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_load();
    test_gaps();
    test_bad_header();
    test_full_depth();
    test_reset_mid_and_busy_start();
    test_base_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Writer-side counterpart to the CPU's instruction fetch path. It accepts a byte stream from a host over a valid/ready handshake and assembles little-endian 32-bit instruction words, which it writes sequentially into instruction memory through a write port. It holds the CPU's PC reset asserted until a complete program has been loaded. It sits between the host/debug byte source and the instruction memory's write side, and drives the PC reset that the testbench initial block drives today.

## Interface

Parameters:
- `ADDR_W`, default 64: instruction-memory address width (bytes).
- `DEPTH_WORDS`, default 256: maximum loadable words; a larger header count is an error.
- `BASE_ADDR`, default 0: byte address of the first word written.

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a load session; sampled in IDLE, DONE and ERR only.
- `byteIn` input 8: stream byte.
- `byteValid` input 1: `byteIn` is valid.
- `byteReady` output 1: loader accepts `byteIn` this cycle. A byte transfers on `byteValid & byteReady`.
- `imemAddr` output ADDR_W: write byte address.
- `imemData` output 32: write word.
- `imemWrite` output 1: one-cycle write strobe.
- `cpuReset` output 1: PC/CPU reset; high until a successful load completes.
- `busy` output 1: session in progress.
- `done` output 1: last session completed successfully.
- `error` output 1: last session aborted on a bad header.

## Operation

- Stream format: 2 header bytes giving word count N (16-bit little-endian, first byte = N[7:0]), then 4·N data bytes. Each word is little-endian: its first byte goes to bits [7:0] and its fourth to bits [31:24].
- States:
  - IDLE: `byteReady`=0. `start` moves to HDR0 and clears `done`/`error`.
  - HDR0: `byteReady`=1. On transfer, latch N[7:0] and move to HDR1.
  - HDR1: `byteReady`=1. On transfer, form N = {byteIn, low byte}.
    - If N==0 or N>DEPTH_WORDS, move to ERR.
    - Otherwise clear the word index and byte counter and move to DATA.
  - DATA: `byteReady`=1. Each transfer shifts the byte into lane [byteCnt] and increments the 2-bit counter. The transfer at byteCnt==3 moves to WRITE.
  - WRITE: `byteReady`=0 and `imemWrite`=1 for exactly this cycle, with `imemAddr` = BASE_ADDR + 4·wordIdx and `imemData` = the assembled word.
    - If wordIdx==N−1, move to DONE.
    - Otherwise increment wordIdx and return to DATA.
  - DONE: `done`=1, `cpuReset`=0, `byteReady`=0. `start` moves to HDR0, reasserts `cpuReset` and clears `done`.
  - ERR: `error`=1, `cpuReset`=1, `byteReady`=0. `start` moves to HDR0 and clears `error`.
- `busy` = state in {HDR0, HDR1, DATA, WRITE}. `start` is ignored while `busy`.
- `cpuReset` is 1 in every state except DONE.
- Address arithmetic is modulo 2^ADDR_W. The word index is wide enough for DEPTH_WORDS−1, and the counter width is ≥16 bits for header compare.
- Bytes presented while `byteReady`=0 are not consumed. The source must hold them.

## Timing

- Reset values: state IDLE, `byteReady`=0, `imemWrite`=0, `imemAddr`=BASE_ADDR, `imemData`=0, `cpuReset`=1, `busy`=0, `done`=0, `error`=0.
- Reset mid-session returns to IDLE the next edge. No further `imemWrite` occurs, and words already written stay written.
- Latency and throughput:
  - The 4th-byte transfer at edge k puts `imemWrite` high in cycle k+1.
  - Throughput is at most 1 word per 5 cycles with `byteValid` held high.
  - Header check takes effect at the edge of the 2nd header byte. ERR is visible the next cycle and no write occurs.
  - `done`=1 and `cpuReset`=0 take effect the cycle after the final `imemWrite` cycle.
  - The `start` in IDLE/DONE/ERR moves the FSM at the same edge; HDR0 `byteReady`=1 the next cycle.
- `reset` and `start` in the same cycle: `reset` wins.
- `imemAddr`/`imemData` hold their last values outside WRITE.

## Test plan

- After reset with no stimulus for 20 cycles: `cpuReset`=1, `byteReady`=0, `imemWrite` never pulses, and `busy`/`done`/`error`=0.
- Load sequence `start`, then bytes 02 00 20 00 80 D2 00 00 00 14 sent back-to-back:
  - writes (0x0, 0xD2800020) then (0x4, 0x14000000), each strobe exactly 1 cycle;
  - `done`=1 and `cpuReset`=0 the cycle after the second strobe.
- Same stream with `byteValid` deasserted for random 0–3 cycles between bytes and held high during WRITE: identical writes, no byte lost or duplicated, `byteReady`=0 in both WRITE cycles.
- Bad headers:
  - header 00 00 gives `error`=1 and no writes;
  - header 01 01 (N=257 > 256) gives `error`=1, `cpuReset`=1 and no writes;
  - a subsequent `start` plus a valid 1-word load gives `done`=1.
- `reset` pulsed after the 2nd data byte of word 1 of a 3-word load: all outputs return to reset values and no further strobe occurs. `start` asserted while `busy` is ignored (state unchanged).
- With BASE_ADDR=0x100: a load from DONE via `start` reasserts `cpuReset`, and a 2-word load writes addresses 0x100 and 0x104.
